// File: rtl/button_bank_if.sv
// Signal bundle between raw button inputs, the button_bank front end and its consumer.
// master drives the raw levels and observes the conditioned outputs; slave is the front end itself.
interface button_bank_if #(
    parameter int N = 4
);
    logic [N-1:0] noisy;
    logic [N-1:0] debounced;
    logic [N-1:0] p_edge;
    logic [N-1:0] n_edge;
    logic [N-1:0] any_edge;
    logic [N-1:0] long_press;
    logic [N-1:0] held;
    logic         event_any;

    modport master (
        output noisy,
        input  debounced, p_edge, n_edge, any_edge, long_press, held, event_any
    );

    modport slave (
        input  noisy,
        output debounced, p_edge, n_edge, any_edge, long_press, held, event_any
    );
endinterface

// File: rtl/button_bank.sv
// Multi-channel push-button front end: synchroniser, counter debouncer, edge detect, long-press.
// Long-press hold logic is built only when BUTTON_BANK_LONG_PRESS_EN is defined; otherwise long_press/held are 0.
module button_bank #(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 500000,
    parameter int HOLD_CYCLES   = 50000000
) (
    input logic          clk,
    input logic          reset_n,
    button_bank_if.slave bus
);
    localparam int             CW       = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic [N-1:0]  deb;
    logic [N-1:0]  deb_q;
    logic [N-1:0]  deb_next;
    logic [CW-1:0] cnt      [N];
    logic [CW-1:0] cnt_next [N];
    logic [N-1:0]  p_edge_w;
    logic [N-1:0]  n_edge_w;
    logic [N-1:0]  long_press_w;
    logic [N-1:0]  held_w;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.noisy;
            sync2 <= sync1;
        end
    end

    // Any return of sync2 to the accepted level restarts the stability count.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            deb_next[i] = deb[i];
            cnt_next[i] = '0;
            if (sync2[i] != deb[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    deb_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
            deb   <= '0;
            deb_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt[i] <= cnt_next[i];
            end
            deb   <= deb_next;
            deb_q <= deb;
        end
    end

    assign p_edge_w = deb & ~deb_q;
    assign n_edge_w = ~deb & deb_q;

`ifdef BUTTON_BANK_LONG_PRESS_EN
    localparam int             HW        = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [N-1:0]  held;
    logic [N-1:0]  held_q;
    logic [N-1:0]  held_next;
    logic [HW-1:0] hcnt      [N];
    logic [HW-1:0] hcnt_next [N];

    // Keyed on deb_next so a release landing on the terminal count wins over held.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            held_next[i] = held[i];
            hcnt_next[i] = '0;
            if (!deb_next[i]) begin
                held_next[i] = 1'b0;
            end else if (deb[i] && !held[i]) begin
                if (hcnt[i] == HOLD_LAST) begin
                    held_next[i] = 1'b1;
                end else begin
                    hcnt_next[i] = hcnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                hcnt[i] <= '0;
            end
            held   <= '0;
            held_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                hcnt[i] <= hcnt_next[i];
            end
            held   <= held_next;
            held_q <= held;
        end
    end

    assign long_press_w = held & ~held_q;
    assign held_w       = held;
`else
    logic unused_hold_cfg;
    assign unused_hold_cfg = (HOLD_CYCLES > 0);
    assign long_press_w    = '0;
    assign held_w          = '0;
`endif

    assign bus.debounced  = deb;
    assign bus.p_edge     = p_edge_w;
    assign bus.n_edge     = n_edge_w;
    assign bus.any_edge   = p_edge_w | n_edge_w;
    assign bus.long_press = long_press_w;
    assign bus.held       = held_w;
    assign bus.event_any  = |(p_edge_w | n_edge_w | long_press_w);
endmodule

// File: tb/tb_button_bank.sv
// Directed self-checking bench for button_bank with STABLE_CYCLES=4, HOLD_CYCLES=8.
// Long-press scenarios are exercised when BUTTON_BANK_LONG_PRESS_EN is defined.
module tb_button_bank;
    localparam int N  = 4;
    localparam int SC = 4;
    localparam int HC = 8;
    // A level stable from the first sampling edge shows on debounced after SC+2 post-edge samples.
    localparam int LAT = SC + 2;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    button_bank_if #(.N(N)) bus ();

    button_bank #(.N(N), .STABLE_CYCLES(SC), .HOLD_CYCLES(HC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic [N-1:0] v);
        bus.noisy = v;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        int first;
        int pulses;
        logic [N-1:0] pe;
        logic [N-1:0] db;
        reset_n   = 1'b0;
        bus.noisy = 4'b1111;
        repeat (3) tick();
        checks++;
        if ({bus.debounced, bus.p_edge, bus.n_edge, bus.any_edge, bus.long_press, bus.held, bus.event_any} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: deb=%b p=%b n=%b lp=%b held=%b ev=%b, required all 0",
                     bus.debounced, bus.p_edge, bus.n_edge, bus.long_press, bus.held, bus.event_any);
        end
        reset_n = 1'b1;
        first   = -1;
        pulses  = 0;
        pe      = '0;
        db      = '0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (bus.p_edge != 0) begin
                pulses++;
                if (first < 0) begin
                    first = t;
                    pe    = bus.p_edge;
                    db    = bus.debounced;
                end
            end
        end
        checks++;
        if (first !== LAT) begin
            errors++;
            $display("FAIL reset_release_latency: got %0d, required %0d", first, LAT);
        end
        checks++;
        if (pe !== 4'b1111 || db !== 4'b1111) begin
            errors++;
            $display("FAIL reset_release_value: p_edge=%b deb=%b, required 1111/1111", pe, db);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL reset_release_pulse_width: %0d cycles, required 1", pulses);
        end
    endtask

    task automatic test_bounce();
        int bad;
        int first;
        int pulses;
        int other;
        settle(4'b0000);
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            bus.noisy[0] = ((t / 2) % 2 == 0);
            tick();
            if ((bus.any_edge != 0) || (bus.debounced != 0)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bounce_quiet: %0d cycles with activity, required 0", bad);
        end
        bus.noisy[0] = 1'b1;
        first  = -1;
        pulses = 0;
        other  = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (bus.p_edge[0]) begin
                pulses++;
                if (first < 0) first = t;
            end
            if ((bus.n_edge != 0) || (bus.p_edge[3:1] != 0)) other++;
        end
        checks++;
        if (first !== LAT) begin
            errors++;
            $display("FAIL bounce_settle_latency: got %0d, required %0d", first, LAT);
        end
        checks++;
        if (pulses !== 1 || other !== 0) begin
            errors++;
            $display("FAIL bounce_single_edge: p_edge[0] cycles=%0d other=%0d, required 1/0", pulses, other);
        end
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        bus.noisy[1] = 1'b1;
        for (int t = 0; t < SC - 1; t++) begin
            tick();
            if (bus.debounced[1] || (bus.any_edge != 0)) bad++;
        end
        bus.noisy[1] = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (bus.debounced[1] || (bus.any_edge != 0)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL glitch_rejected: %0d cycles with activity, required 0", bad);
        end
        checks++;
        if (bus.debounced !== 4'b0001) begin
            errors++;
            $display("FAIL glitch_final_level: deb=%b, required 0001", bus.debounced);
        end
    endtask

    task automatic test_multi_channel();
        int first;
        settle(4'b0100);
        checks++;
        if (bus.debounced !== 4'b0100) begin
            errors++;
            $display("FAIL multi_preset: deb=%b, required 0100", bus.debounced);
        end
        bus.noisy = 4'b1001;
        first = -1;
        for (int t = 1; t <= 20 && first < 0; t++) begin
            tick();
            if (bus.any_edge != 0) first = t;
        end
        checks++;
        if (first !== LAT) begin
            errors++;
            $display("FAIL multi_latency: got %0d, required %0d", first, LAT);
        end
        checks++;
        if (bus.p_edge !== 4'b1001 || bus.n_edge !== 4'b0100 || bus.any_edge !== 4'b1101 || bus.event_any !== 1'b1) begin
            errors++;
            $display("FAIL multi_edges: p=%b n=%b any=%b ev=%b, required 1001/0100/1101/1",
                     bus.p_edge, bus.n_edge, bus.any_edge, bus.event_any);
        end
        tick();
        checks++;
        if (bus.any_edge !== 4'b0000 || bus.event_any !== 1'b0 || bus.debounced !== 4'b1001) begin
            errors++;
            $display("FAIL multi_after: any=%b ev=%b deb=%b, required 0000/0/1001",
                     bus.any_edge, bus.event_any, bus.debounced);
        end
    endtask

`ifdef BUTTON_BANK_LONG_PRESS_EN
    task automatic test_long_press();
        int first;
        int drop;
        int p_cnt;
        int n_cnt;
        int lp_cnt;
        int hi_cnt;
        int dur;
        bus.noisy = 4'b1101;
        first = -1;
        for (int t = 1; t <= 20 && first < 0; t++) begin
            tick();
            if (bus.p_edge[2]) first = t;
        end
        checks++;
        if (first !== LAT) begin
            errors++;
            $display("FAIL long_rise_latency: got %0d, required %0d", first, LAT);
        end
        first = -1;
        for (int t = 1; t <= 20 && first < 0; t++) begin
            tick();
            if (bus.long_press != 0) first = t;
        end
        checks++;
        if (first !== HC) begin
            errors++;
            $display("FAIL long_press_delay: got %0d, required %0d", first, HC);
        end
        checks++;
        if (bus.long_press !== 4'b0100 || bus.held !== 4'b0100 || bus.event_any !== 1'b1) begin
            errors++;
            $display("FAIL long_press_value: lp=%b held=%b ev=%b, required 0100/0100/1",
                     bus.long_press, bus.held, bus.event_any);
        end
        tick();
        checks++;
        if (bus.long_press !== 4'b0000 || bus.held !== 4'b0100) begin
            errors++;
            $display("FAIL long_press_pulse: lp=%b held=%b, required 0000/0100", bus.long_press, bus.held);
        end
        repeat (5) tick();
        bus.noisy = 4'b1001;
        first = -1;
        drop  = 0;
        for (int t = 1; t <= 20 && first < 0; t++) begin
            tick();
            if (bus.n_edge != 0) first = t;
            else if (!bus.held[2]) drop++;
        end
        checks++;
        if (first !== LAT || drop !== 0) begin
            errors++;
            $display("FAIL held_until_release: latency=%0d early_drops=%0d, required %0d/0", first, drop, LAT);
        end
        checks++;
        if (bus.n_edge !== 4'b0100 || bus.held !== 4'b0000) begin
            errors++;
            $display("FAIL held_clear: n=%b held=%b, required 0100/0000", bus.n_edge, bus.held);
        end
        for (int k = 0; k < 2; k++) begin
            dur    = HC - 1 + k;
            p_cnt  = 0;
            n_cnt  = 0;
            lp_cnt = 0;
            hi_cnt = 0;
            bus.noisy = 4'b1101;
            for (int t = 0; t < dur + 14; t++) begin
                if (t == dur) bus.noisy = 4'b1001;
                tick();
                if (bus.p_edge[2]) p_cnt++;
                if (bus.n_edge[2]) n_cnt++;
                if ((bus.long_press != 0) || (bus.held != 0)) lp_cnt++;
                if (bus.debounced[2]) hi_cnt++;
            end
            checks++;
            if (p_cnt !== 1 || n_cnt !== 1 || lp_cnt !== 0 || hi_cnt !== dur) begin
                errors++;
                $display("FAIL short_press_%0d: p=%0d n=%0d lp_or_held=%0d high=%0d, required 1/1/0/%0d",
                         dur, p_cnt, n_cnt, lp_cnt, hi_cnt, dur);
            end
        end
    endtask
`else
    task automatic test_no_long_press();
        int bad;
        bad = 0;
        bus.noisy = 4'b1101;
        for (int t = 0; t < 30; t++) begin
            tick();
            if ((bus.long_press != 0) || (bus.held != 0)) bad++;
        end
        bus.noisy = 4'b1001;
        repeat (12) tick();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL no_long_press: %0d cycles with long_press/held, required 0", bad);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int first;
        settle(4'b0010);
        bus.noisy = 4'b0011;
        repeat (3) tick();
        checks++;
        if (bus.debounced !== 4'b0010) begin
            errors++;
            $display("FAIL mid_preset: deb=%b, required 0010", bus.debounced);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.debounced, bus.p_edge, bus.n_edge, bus.any_edge, bus.long_press, bus.held, bus.event_any} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: deb=%b p=%b n=%b lp=%b held=%b ev=%b, required all 0",
                     bus.debounced, bus.p_edge, bus.n_edge, bus.long_press, bus.held, bus.event_any);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        first = -1;
        for (int t = 1; t <= 20 && first < 0; t++) begin
            tick();
            if (bus.p_edge != 0) first = t;
        end
        checks++;
        if (first !== LAT || bus.p_edge !== 4'b0011) begin
            errors++;
            $display("FAIL mid_redebounce: latency=%0d p_edge=%b, required %0d/0011", first, bus.p_edge, LAT);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.noisy = '0;
        test_reset();
        test_bounce();
        test_glitch();
        test_multi_channel();
`ifdef BUTTON_BANK_LONG_PRESS_EN
        test_long_press();
`else
        test_no_long_press();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_bank.md
# button_bank

Parametrised multi-channel push-button front end: per-channel two-flop synchroniser, counter-based debouncer with configurable stable time, edge detection and optional long-press detection. Sits between raw board inputs (switches, keys) and control logic, replacing per-button debounce/edge pairs with one vectorised block. All channels are independent and share only clock, reset and the summary flag.

## Interface

Parameters:
- N, 4, number of button channels (≥1)
- STABLE_CYCLES, 500000, consecutive cycles a synchronised level must hold before it is accepted (≥2)
- HOLD_CYCLES, 50000000, cycles a debounced press must persist to count as a long press (≥2; used only with long-press feature)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- noisy  input  N  raw asynchronous button levels, bit i = channel i
- debounced  output  N  accepted stable level per channel
- p_edge  output  N  one-cycle pulse on debounced 0→1
- n_edge  output  N  one-cycle pulse on debounced 1→0
- any_edge  output  N  p_edge | n_edge
- event_any  output  1  OR-reduction of any_edge (and long_press when enabled)
- long_press  output  N  one-cycle pulse when a press reaches HOLD_CYCLES
- held  output  N  high from long_press until release

## Operation

- Counter widths derived internally with $clog2; no width parameters exposed.
- Per channel: sync1 ← noisy[i], sync2 ← sync1. Only sync2 feeds the debouncer.
- Debounce counter cnt: if sync2 == debounced, cnt ← 0. Else if cnt == STABLE_CYCLES−1, debounced ← sync2 and cnt ← 0; else cnt ← cnt+1. Any glitch back to the accepted level restarts the count from 0.
- Edge detect: register deb_q ← debounced; p_edge = debounced & ~deb_q, n_edge = ~debounced & deb_q. Pulses are exactly one cycle, high in the first cycle debounced shows the new value.
- Long press (feature enabled): hold counter hcnt cleared whenever debounced == 0 or held == 1. While debounced == 1 and held == 0, hcnt increments; when hcnt == HOLD_CYCLES−1, held ← 1. long_press = held & ~held_q. held clears on the same edge debounced falls to 0.
- Channels never interact; simultaneous events on several channels are all reported in the same cycle.

## Timing

- Reset (async assert, sync release by design): sync flops, cnt, hcnt, debounced, deb_q, held, held_q all 0. Thus every output is 0 during and immediately after reset.
- A level change stable from edge k (first edge sampling it): sync2 updates at edge k+1, debounced updates at edge k+STABLE_CYCLES+1, edge pulse high for the cycle following that edge.
- long_press pulses HOLD_CYCLES cycles after debounced rises, provided no release in between.
- Release on the exact cycle hcnt would hit HOLD_CYCLES−1: debounced falling wins; no long_press, held stays 0.
- Reset asserted mid-count: all counters and outputs drop to 0 immediately; a button held through reset is re-debounced from scratch and produces a fresh p_edge.
- No output depends combinationally on noisy.

## Configuration

- BUTTON_BANK_LONG_PRESS_EN defined: hold counters, held, held_q implemented as above; long_press included in event_any.
- Not defined: no hold logic synthesised; long_press and held tied to 0; event_any = |any_edge. Port list identical in both builds.

## Test plan

- Reset: reset_n low with noisy=4'b1111 → all outputs 0; release, hold inputs → debounced=4'b1111 at edge STABLE_CYCLES+1 after first sample, p_edge=4'b1111 one cycle (use STABLE_CYCLES=4, HOLD_CYCLES=8).
- Bounce: ch0 toggles every 2 cycles for 20 cycles then settles high → single p_edge[0], exactly STABLE_CYCLES+1 edges after settling; no pulses during bounce.
- Glitch: ch1 high for STABLE_CYCLES−1 cycles then low → debounced[1] stays 0, no edges.
- Multi-channel: ch0 and ch3 rise same cycle, ch2 falls → p_edge=4'b1001, n_edge=4'b0100 same cycle, event_any=1 for one cycle.
- Long press (macro on): ch2 held 20 cycles → long_press[2] pulse 8 cycles after debounced[2] rise, held[2] high until n_edge[2] edge; release at 7 cycles → no long_press.
- Reset mid-operation: assert reset_n low while ch0 counting and ch1 held → outputs 0 immediately; after release ch1 re-debounces and emits new p_edge[1].
